// File: rtl/acc_dump.sv
// Debug readout: snapshots the accumulator on start and streams HEADER, data bytes, XOR checksum.
// One byte per cycle when tx_ready is high; tx_data/tx_valid hold steady while stalled.
module acc_dump #(
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] acc_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_FIN} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] snap_q;
  logic [7:0]        chk_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [CW-1:0]     cnt_d;
  logic [7:0]        first_byte_d;
  logic [7:0]        next_byte_d;
  logic [7:0]        chk_d;
  logic              last_d;

  function automatic logic [7:0] pick(input logic [DATA_W-1:0] v, input logic [CW-1:0] c);
    int                idx;
    logic [DATA_W-1:0] sh;
    idx = MSB_FIRST ? (NB - 1 - int'(c)) : int'(c);
    sh  = v >> (idx * 8);
    return sh[7:0];
  endfunction

  // tx_data_q always holds the byte in flight, so it is folded into the checksum on transfer
  assign cnt_d        = cnt_q + 1'b1;
  assign first_byte_d = pick(snap_q, '0);
  assign next_byte_d  = pick(snap_q, cnt_d);
  assign chk_d        = chk_q ^ tx_data_q;
  assign last_d       = (cnt_q == CW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      snap_q     <= '0;
      chk_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            snap_q     <= acc_data;
            chk_q      <= HEADER;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_HDR;
          end
        end
        S_HDR: begin
          if (tx_ready) begin
            cnt_q     <= '0;
            tx_data_q <= first_byte_d;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_ready) begin
            chk_q <= chk_d;
            if (last_d) begin
              tx_data_q <= chk_d;
              state_q   <= S_CHK;
            end else begin
              cnt_q     <= cnt_d;
              tx_data_q <= next_byte_d;
            end
          end
        end
        S_CHK: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b1;
            state_q    <= S_FIN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_acc_dump.sv
// Bench for acc_dump: three configurations, scoreboard queues filled at stimulus time, negedge monitor.
module tb_acc_dump;

  logic        clk;
  logic        rst_n;
  logic        st   [3];
  logic        rdy  [3];
  logic [7:0]  txd  [3];
  logic        vld  [3];
  logic        bsy  [3];
  logic        dn   [3];
  logic [15:0] acc0;
  logic [31:0] acc1;
  logic [15:0] acc2;

  int total = 0;
  int bad   = 0;
  int dcnt  [3];
  bit prev_stall [3];
  logic [7:0] prev_dat [3];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  acc_dump #(.DATA_W(16), .HEADER(8'hA5), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .acc_data(acc0), .tx_data(txd[0]),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]));
  acc_dump #(.DATA_W(32), .HEADER(8'hA5), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .acc_data(acc1), .tx_data(txd[1]),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]));
  acc_dump #(.DATA_W(16), .HEADER(8'hA5), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .acc_data(acc2), .tx_data(txd[2]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame built straight from the frame definition: header, bytes by index, XOR.
  task automatic push_frame(input int u, input int nb, input bit msb, input logic [63:0] v);
    logic [7:0] b[$];
    logic [7:0] c;
    logic [7:0] by;
    int idx;
    b.push_back(8'hA5);
    c = 8'hA5;
    for (int k = 0; k < nb; k++) begin
      idx = msb ? (nb - 1 - k) : k;
      by  = 8'(v >> (8 * idx));
      b.push_back(by);
      c = c ^ by;
    end
    b.push_back(c);
    foreach (b[j]) begin
      case (u)
        0: q0.push_back(b[j]);
        1: q1.push_back(b[j]);
        default: q2.push_back(b[j]);
      endcase
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    bit have;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        prev_stall[i] = 1'b0;
      end else begin
        if (dn[i]) dcnt[i]++;
        if (prev_stall[i]) begin
          chk($sformatf("stall_vld_u%0d", i), vld[i], 1'b1);
          chk($sformatf("stall_dat_u%0d", i), txd[i], prev_dat[i]);
        end
        if (vld[i] && rdy[i]) begin
          have = 1'b0;
          e = 8'h00;
          case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
          endcase
          chk($sformatf("unexpected_byte_u%0d", i), {63'd0, have}, 64'd1);
          if (have) chk($sformatf("byte_u%0d", i), txd[i], e);
        end
        prev_stall[i] = vld[i] && !rdy[i];
        prev_dat[i]   = txd[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},  txd[0], 8'h00);
    chk({tag, "_valid"}, vld[0], 1'b0);
    chk({tag, "_busy"},  bsy[0], 1'b0);
    chk({tag, "_done"},  dn[0],  1'b0);
  endtask

  initial begin
    int bc;
    int d0;
    int guard;
    logic [31:0] v;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; rdy[i] = 1'b1; dcnt[i] = 0; prev_stall[i] = 1'b0; prev_dat[i] = 8'h00;
    end
    acc0 = '0; acc1 = '0; acc2 = '0;
    tick(); tick();
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // Basic frames on all three configurations, ready held high
    acc0 = 16'h1234; acc1 = 32'hDEADBEEF; acc2 = 16'h1234;
    push_frame(0, 2, 1'b1, 64'h1234);
    push_frame(1, 4, 1'b1, 64'hDEADBEEF);
    push_frame(2, 2, 1'b0, 64'h1234);
    st[0] = 1'b1; st[1] = 1'b1; st[2] = 1'b1;
    tick();
    st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
    chk("first_valid", vld[0], 1'b1);
    chk("first_header", txd[0], 8'hA5);
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      if (bsy[0]) bc++;
      tick();
    end
    chk("busy_cycles", bc, 5);
    chk("done_u0", dcnt[0], 1);
    chk("done_u1", dcnt[1], 1);
    chk("done_u2", dcnt[2], 1);
    chk("drain_u0", q0.size(), 0);
    chk("drain_u1", q1.size(), 0);
    chk("drain_u2", q2.size(), 0);

    // Random frames: random ready, live acc_data churn, ignored starts while busy
    for (int f = 0; f < 15; f++) begin
      d0 = dcnt[0];
      v = $urandom;
      acc0 = v[15:0];
      push_frame(0, 2, 1'b1, {48'd0, v[15:0]});
      rdy[0] = 1'($urandom_range(0, 1));
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      guard = 0;
      while (bsy[0] && guard < 300) begin
        rdy[0] = 1'($urandom_range(0, 1));
        acc0 = 16'($urandom);
        st[0] = ($urandom_range(0, 3) == 0);
        tick();
        guard++;
      end
      st[0] = 1'b0;
      rdy[0] = 1'b1;
      chk("frame_timeout", {63'd0, guard < 300}, 64'd1);
      repeat (3) tick();
      chk("rand_done", dcnt[0] - d0, 1);
      chk("rand_drain", q0.size(), 0);
      chk("rand_idle_valid", vld[0], 1'b0);
    end

    // Reset while the first data byte is stalled
    d0 = dcnt[0];
    acc0 = 16'h1234;
    push_frame(0, 2, 1'b1, 64'h1234);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    rdy[0] = 1'b0;
    tick();
    chk("pending_12", txd[0], 8'h12);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    q0.delete();
    tick();
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    tick();
    acc0 = 16'h0000;
    push_frame(0, 2, 1'b1, 64'h0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (10) tick();
    chk("post_reset_done", dcnt[0] - d0, 1);
    chk("post_reset_drain", q0.size(), 0);

    // Start held high: accepted on first IDLE after FIN only, never during FIN
    d0 = dcnt[0];
    acc0 = 16'hABCD;
    push_frame(0, 2, 1'b1, 64'hABCD);
    push_frame(0, 2, 1'b1, 64'hABCD);
    st[0] = 1'b1;
    repeat (12) tick();
    st[0] = 1'b0;
    repeat (10) tick();
    chk("held_start_frames", dcnt[0] - d0, 2);
    chk("held_start_drain", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
